// File: rtl/rng_sample_buffer_if.sv
// Generator and host signals of the RNG sample buffer, bundled as one interface.
interface rng_sample_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             src_restart;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             health_fail;
  logic             timeout_err;
  logic             clear_err;

  // Generator/host side
  modport master (
    output src_valid, src_data, rd_en, clear_err,
    input  src_restart, rd_data, empty, full, count, health_fail, timeout_err
  );

  // Buffer side
  modport slave (
    input  src_valid, src_data, rd_en, clear_err,
    output src_restart, rd_data, empty, full, count, health_fail, timeout_err
  );
endinterface

// File: rtl/rng_sample_buffer.sv
// Requests samples from the RNG, screens them with a repetition-count test and
// queues passing samples in a show-ahead FIFO for the host.
module rng_sample_buffer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REPEAT_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 32
) (
  input  logic               clk,
  input  logic               reset_L,
  rng_sample_buffer_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = $clog2(REPEAT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             valid_q;
  logic             restart_q;
  logic             cap_v_q, cap_v_d;
  logic [WIDTH-1:0] cap_d_q;
  logic             tmo_fire_c;
  logic             rise_c;

  logic [WIDTH-1:0] last_q;
  logic [RW-1:0]    run_q, run_nxt_c;
  logic             health_fail_q, timeout_err_q;
  logic             trip_c;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] rd_data_q, head_d;
  logic             push_c, pop_c;

  assign rise_c = bus.src_valid & ~valid_q;
  assign pop_c  = bus.rd_en & ~empty_q;

  // Request FSM: one outstanding request, none while a capture is still being screened
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    cap_v_d    = 1'b0;
    tmo_fire_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!health_fail_q && !cap_v_q && (!full_q || pop_c)) state_d = REQ;
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (rise_c) begin
          cap_v_d = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 2)) begin
          tmo_fire_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, valid edge history, restart pulse and capture stage
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      restart_q <= 1'b0;
      cap_v_q   <= 1'b0;
      cap_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      valid_q   <= bus.src_valid;
      restart_q <= (state_d == REQ);
      cap_v_q   <= cap_v_d;
      if (cap_v_d) cap_d_q <= bus.src_data;
    end
  end

  // Repetition-count test on the captured sample; a coinciding clear suppresses the trip
  always_comb begin
    run_nxt_c = RW'(1);
    if (run_q != '0 && cap_d_q == last_q) run_nxt_c = run_q + RW'(1);
    trip_c = cap_v_q && (run_nxt_c == RW'(REPEAT_LIMIT)) && !bus.clear_err;
    push_c = cap_v_q && !trip_c && (!full_q || pop_c);
  end

  // Sticky error flags and repetition state
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      health_fail_q <= 1'b0;
      timeout_err_q <= 1'b0;
      run_q         <= '0;
      last_q        <= '0;
    end else if (bus.clear_err) begin
      health_fail_q <= 1'b0;
      timeout_err_q <= 1'b0;
      run_q         <= '0;
    end else begin
      if (tmo_fire_c) timeout_err_q <= 1'b1;
      if (cap_v_q) begin
        run_q  <= run_nxt_c;
        last_q <= cap_d_q;
        if (trip_c) health_fail_q <= 1'b1;
      end
    end
  end

  // Next occupancy and next show-ahead head
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
    head_d = rd_data_q;
    if (pop_c)                   head_d = (count_q == CW'(1)) ? cap_d_q : mem_q[rd_ptr_q + AW'(1)];
    else if (push_c && empty_q)  head_d = cap_d_q;
  end

  // FIFO pointers, flags and registered head
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CW'(DEPTH));
      rd_data_q <= head_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= cap_d_q;
  end

  assign bus.src_restart = restart_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.count       = count_q;
  assign bus.health_fail = health_fail_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_rng_sample_buffer.sv
// Directed bench for rng_sample_buffer: generator model, host driver and a
// scoreboard monitor that checks every popped sample against the expected order.
module tb_rng_sample_buffer;
  localparam int unsigned WIDTH        = 8;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned REPEAT_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 32;
  localparam int unsigned GEN_DELAY    = 9;

  logic clk     = 1'b0;
  logic reset_L = 1'b0;

  int n_cmp        = 0;
  int n_err        = 0;
  int cyc          = 0;
  int restarts     = 0;
  int last_req_cyc = 0;
  bit gen_mute     = 1'b0;

  logic [WIDTH-1:0] gen_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] gen_d;
  event gen_fire;

  rng_sample_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rng_sample_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .REPEAT_LIMIT(REPEAT_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] d, input bit expect_push);
    gen_q.push_back(d);
    if (expect_push) exp_q.push_back(d);
  endtask

  task automatic wait_count(input int n, input int budget);
    int k = 0;
    while (bus.count !== n[3:0] && k < budget) begin tick(); k++; end
    check($sformatf("count_reach_%0d", n), 32'(bus.count), n);
  endtask

  task automatic wait_restarts(input int n, input int budget);
    int k = 0;
    while (restarts != n && k < budget) begin tick(); k++; end
    check($sformatf("restarts_reach_%0d", n), restarts, n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_src_restart"}, 32'(bus.src_restart), 0);
    check({tag, "_count"},       32'(bus.count),       0);
    check({tag, "_empty"},       32'(bus.empty),       1);
    check({tag, "_full"},        32'(bus.full),        0);
    check({tag, "_rd_data"},     32'(bus.rd_data),     0);
    check({tag, "_health_fail"}, 32'(bus.health_fail), 0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  // Generator model: drops valid on restart, presents the next queued sample GEN_DELAY cycles later
  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.src_restart === 1'b1) begin
        restarts++;
        last_req_cyc  = cyc;
        bus.src_valid = 1'b0;
        if (!gen_mute && gen_q.size() > 0) begin
          gen_d = gen_q.pop_front();
          repeat (GEN_DELAY - 1) @(negedge clk);
          bus.src_data  = gen_d;
          bus.src_valid = 1'b1;
          ->gen_fire;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted pop must present the oldest expected sample
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rd_en === 1'b1 && bus.empty === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: rd_data %0h, no expected sample", bus.rd_data);
        end else begin
          check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    int base;
    bus.rd_en     = 1'b0;
    bus.clear_err = 1'b0;

    // Reset state
    tick(3);
    check_reset_vals("reset");

    // Reset release and fill with eight distinct samples
    load(8'h3A, 1); load(8'h7C, 1); load(8'h11, 1); load(8'h21, 1);
    load(8'h32, 1); load(8'h43, 1); load(8'h54, 1); load(8'h65, 1);
    reset_L = 1'b1;
    wait_count(1, 60);
    check("first_head", 32'(bus.rd_data), 32'h3A);
    wait_count(2, 60);
    wait_count(3, 60);
    check("head_after_3", 32'(bus.rd_data), 32'h3A);
    wait_count(8, 200);
    check("full_at_8", 32'(bus.full), 1);
    check("restarts_fill", restarts, 8);
    tick(50);
    check("no_req_while_full", restarts, 8);
    check("count_hold_full", 32'(bus.count), 8);

    // One pop frees a slot: exactly one new request
    load(8'h76, 1);
    base = restarts;
    pop1();
    check("count_after_pop", 32'(bus.count), 7);
    check("head_after_pop", 32'(bus.rd_data), 32'h7C);
    wait_count(8, 60);
    tick(40);
    check("one_new_request", restarts, base + 1);

    // Pop coinciding with a push keeps occupancy; order across pointer wrap
    load(8'h87, 1); load(8'h98, 1);
    pop1();
    check("count_before_simul", 32'(bus.count), 7);
    @(gen_fire);
    tick();
    pop1();
    check("count_simul_push_pop", 32'(bus.count), 7);
    wait_count(8, 60);

    // Drain all eight with the generator silent; pop on empty is ignored
    gen_mute = 1'b1;
    bus.rd_en = 1'b1;
    tick(8);
    bus.rd_en = 1'b0;
    check("count_drained", 32'(bus.count), 0);
    check("empty_drained", 32'(bus.empty), 1);
    pop1();
    check("count_pop_empty", 32'(bus.count), 0);
    check("empty_pop_empty", 32'(bus.empty), 1);

    // Timeout fires TIMEOUT cycles after the request, then a fresh request
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 100) begin tick(); k++; end
    check("timeout_err_set", 32'(bus.timeout_err), 1);
    check("timeout_latency", 32'(cyc - last_req_cyc), TIMEOUT);
    gen_mute = 1'b0;
    load(8'hA5, 1); load(8'hA5, 1); load(8'hA5, 1); load(8'hA5, 0);
    base = restarts;
    wait_restarts(base + 1, 5);
    check("count_after_timeout", 32'(bus.count), 0);
    pulse_clear();
    check("timeout_err_cleared", 32'(bus.timeout_err), 0);

    // Repetition test trips on the fourth identical sample
    k = 0;
    while (bus.health_fail !== 1'b1 && k < 300) begin tick(); k++; end
    check("health_fail_set", 32'(bus.health_fail), 1);
    check("count_at_trip", 32'(bus.count), 3);
    base = restarts;
    tick(60);
    check("no_req_while_fail", restarts, base);
    bus.rd_en = 1'b1;
    tick(3);
    bus.rd_en = 1'b0;
    check("count_read_under_fail", 32'(bus.count), 0);
    check("still_no_req", restarts, base);

    // Clearing resumes requests
    load(8'hB6, 1); load(8'hC7, 1); load(8'hD8, 1); load(8'hE9, 1);
    load(8'hFA, 1); load(8'h0B, 1); load(8'h1C, 1); load(8'h2D, 1);
    pulse_clear();
    check("health_fail_cleared", 32'(bus.health_fail), 0);
    wait_count(8, 300);
    check("full_after_resume", 32'(bus.full), 1);
    check("restarts_after_resume", restarts, base + 8);

    // Reset during WAIT aborts the request; valid rising under reset is not captured
    load(8'h77, 0); load(8'h66, 0);
    base = restarts;
    pop1();
    wait_restarts(base + 1, 10);
    tick(3);
    reset_L = 1'b0;
    tick(14);
    check("valid_seen_in_reset", 32'(bus.src_valid), 1);
    check_reset_vals("mid_wait_reset");
    exp_q.delete();
    exp_q.push_back(8'h66);
    reset_L = 1'b1;
    wait_count(1, 60);
    check("head_after_reset", 32'(bus.rd_data), 32'h66);
    pop1();
    check("count_final", 32'(bus.count), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
